// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types, funct3 codes and alignment check for the memory port arbiter
//
// Contents:
//   F3_*          load/store size and sign codes, matching the core's funct3 encoding
//   arb_src_e     which requester owns an access (none / fetch / load-store)
//   mem_rsp_t     registered response: owner, misalignment flag, read data
//   is_misaligned true when the low address bits break the access size
package mem_arb_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Response data width; the arbiter's DWIDTH must match it.
    localparam int RSP_DWIDTH = 32;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_IF   = 2'd1,
        SRC_LS   = 2'd2
    } arb_src_e;

    typedef struct packed {
        arb_src_e                src;
        logic                    err;
        logic [RSP_DWIDTH-1:0]   data;
    } mem_rsp_t;

    // Only the two low address bits matter; funct3[1:0] is the log2 access size.
    function automatic logic is_misaligned(input logic [1:0] addr_lo, input logic [2:0] funct3);
        case (funct3[1:0])
            2'b10:   return (addr_lo != 2'b00);
            2'b01:   return addr_lo[0];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// rtl/mem_arb_starve_ctr.sv - saturating count of consecutive denied fetch cycles
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   inc_i        fetch requested and was denied this cycle
//   clr_i        fetch was granted or not requesting; restart the count
//   at_limit_o   count has reached LIMIT, fetch must win the next contest
module mem_arb_starve_ctr #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_limit_o
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 4'd0;
        end else if (inc_i && (cnt_q != 4'(LIMIT))) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit_o = (cnt_q == 4'(LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between instruction fetch and load/store
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   if_req_i/if_addr_i            fetch request (always a word load)
//   if_gnt_o                      fetch accepted this cycle
//   if_rvalid_o/if_rdata_o/if_err_o   fetch response, one cycle after grant
//   ls_req_i/ls_we_i/ls_addr_i/ls_wdata_i/ls_funct3_i   load/store request
//   ls_gnt_o                      load/store accepted this cycle
//   ls_rvalid_o/ls_rdata_o/ls_err_o   load/store response, one cycle after grant
//   mem_*_o                       address, write data, enables and funct3 to the memory
//   mem_data_i                    combinational read data from the memory
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AWIDTH       = 32,
    parameter int DWIDTH       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [AWIDTH-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DWIDTH-1:0] if_rdata_o,
    output logic              if_err_o,
    input  logic              ls_req_i,
    input  logic              ls_we_i,
    input  logic [AWIDTH-1:0] ls_addr_i,
    input  logic [DWIDTH-1:0] ls_wdata_i,
    input  logic [2:0]        ls_funct3_i,
    output logic              ls_gnt_o,
    output logic              ls_rvalid_o,
    output logic [DWIDTH-1:0] ls_rdata_o,
    output logic              ls_err_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_data_o,
    output logic              mem_read_en_o,
    output logic              mem_write_en_o,
    output logic [2:0]        mem_funct3_o,
    input  logic [DWIDTH-1:0] mem_data_i
);

    logic     at_limit;
    logic     if_win;
    logic     ls_win;
    logic     if_mis;
    logic     ls_mis;
    mem_rsp_t rsp_q;
    mem_rsp_t rsp_d;

    // Load/store normally wins; fetch takes over once it has been starved long enough.
    assign if_win = !rst && if_req_i && (!ls_req_i || at_limit);
    assign ls_win = !rst && ls_req_i && !if_win;

    assign if_gnt_o = if_win;
    assign ls_gnt_o = ls_win;

    assign if_mis = is_misaligned(if_addr_i[1:0], F3_LW);
    assign ls_mis = is_misaligned(ls_addr_i[1:0], ls_funct3_i);

    mem_arb_starve_ctr #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve_ctr (
        .clk       (clk),
        .rst       (rst),
        .inc_i     (if_req_i && !if_win),
        .clr_i     (!if_req_i || if_win),
        .at_limit_o(at_limit)
    );

    // A misaligned grant is consumed here: the memory sees an idle cycle.
    always_comb begin
        mem_addr_o     = '0;
        mem_data_o     = '0;
        mem_read_en_o  = 1'b0;
        mem_write_en_o = 1'b0;
        mem_funct3_o   = 3'b000;
        if (if_win && !if_mis) begin
            mem_addr_o    = if_addr_i;
            mem_funct3_o  = F3_LW;
            mem_read_en_o = 1'b1;
        end else if (ls_win && !ls_mis) begin
            mem_addr_o     = ls_addr_i;
            mem_funct3_o   = ls_funct3_i;
            mem_read_en_o  = !ls_we_i;
            mem_write_en_o = ls_we_i;
            mem_data_o     = ls_we_i ? ls_wdata_i : '0;
        end
    end

    always_comb begin
        rsp_d = '0;
        if (if_win) begin
            rsp_d.src = SRC_IF;
            rsp_d.err = if_mis;
        end else if (ls_win) begin
            rsp_d.src = SRC_LS;
            rsp_d.err = ls_mis;
        end
        // mem_read_en_o already excludes stores, misaligned and idle cycles.
        if (mem_read_en_o) begin
            rsp_d.data = mem_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_q <= '0;
        end else begin
            rsp_q <= rsp_d;
        end
    end

    assign if_rvalid_o = (rsp_q.src == SRC_IF);
    assign if_err_o    = if_rvalid_o && rsp_q.err;
    assign if_rdata_o  = if_rvalid_o ? rsp_q.data : '0;
    assign ls_rvalid_o = (rsp_q.src == SRC_LS);
    assign ls_err_o    = ls_rvalid_o && rsp_q.err;
    assign ls_rdata_o  = ls_rvalid_o ? rsp_q.data : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o, if_rvalid_o, if_err_o;
    logic [31:0] if_rdata_o;
    logic        ls_req_i, ls_we_i;
    logic [31:0] ls_addr_i, ls_wdata_i;
    logic [2:0]  ls_funct3_i;
    logic        ls_gnt_o, ls_rvalid_o, ls_err_o;
    logic [31:0] ls_rdata_o;
    logic [31:0] mem_addr_o, mem_data_o, mem_data_i;
    logic        mem_read_en_o, mem_write_en_o;
    logic [2:0]  mem_funct3_o;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(.AWIDTH(32), .DWIDTH(32), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
        .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_addr_i(ls_addr_i),
        .ls_wdata_i(ls_wdata_i), .ls_funct3_i(ls_funct3_i), .ls_gnt_o(ls_gnt_o),
        .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o), .ls_err_o(ls_err_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_read_en_o(mem_read_en_o),
        .mem_write_en_o(mem_write_en_o), .mem_funct3_o(mem_funct3_o), .mem_data_i(mem_data_i)
    );

    always #5 clk = ~clk;

    // Device memory: byte array written only from the DUT's memory outputs.
    bit [7:0]  dev_bytes [bit [31:0]];
    // Reference memory: word array written from the requests the model predicts as performed.
    bit [31:0] ref_words [bit [29:0]];

    // Model state and per-cycle predictions.
    int        denied = 0;
    bit        p_if_v, p_if_e, p_ls_v, p_ls_e;
    bit [31:0] p_if_d, p_ls_d;
    bit        n_if_v, n_if_e, n_ls_v, n_ls_e;
    bit [31:0] n_if_d, n_ls_d;
    bit        e_if_g, e_ls_g, e_re, e_we;
    bit [31:0] e_addr, e_wd;
    bit [2:0]  e_f3;
    int        new_denied;

    // DUT snapshot taken mid-cycle.
    logic        s_if_g, s_ls_g, s_re, s_we;
    logic [31:0] s_addr, s_wd;
    logic [2:0]  s_f3;

    function automatic bit [7:0] dev_byte(input bit [31:0] a);
        return dev_bytes.exists(a) ? dev_bytes[a] : 8'h00;
    endfunction

    function automatic logic [31:0] dev_read(input logic [31:0] a, input logic [2:0] f3);
        bit [7:0] b0, b1, b2, b3;
        b0 = dev_byte(a); b1 = dev_byte(a + 1); b2 = dev_byte(a + 2); b3 = dev_byte(a + 3);
        case (f3)
            3'b000:  return {{24{b0[7]}}, b0};
            3'b001:  return {{16{b1[7]}}, b1, b0};
            3'b100:  return {24'h0, b0};
            3'b101:  return {16'h0, b1, b0};
            default: return {b3, b2, b1, b0};
        endcase
    endfunction

    task automatic dev_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
        int n;
        n = 1 << f3[1:0];
        for (int i = 0; i < n; i++) dev_bytes[a + i] = d[8*i +: 8];
    endtask

    function automatic bit [31:0] ref_load(input bit [31:0] a, input bit [2:0] f3);
        bit [31:0] w, v;
        w = ref_words.exists(a[31:2]) ? ref_words[a[31:2]] : 32'h0;
        v = w >> (a[1:0] * 8);
        case (f3)
            3'd0:    return (v & 32'hFF) | (v[7] ? 32'hFFFFFF00 : 32'h0);
            3'd4:    return v & 32'hFF;
            3'd1:    return (v & 32'hFFFF) | (v[15] ? 32'hFFFF0000 : 32'h0);
            3'd5:    return v & 32'hFFFF;
            default: return w;
        endcase
    endfunction

    task automatic ref_store(input bit [31:0] a, input bit [31:0] d, input bit [2:0] f3);
        bit [31:0] w, mask;
        int sh;
        sh = a[1:0] * 8;
        w = ref_words.exists(a[31:2]) ? ref_words[a[31:2]] : 32'h0;
        mask = (f3[1:0] == 2'd0) ? 32'hFF : (f3[1:0] == 2'd1) ? 32'hFFFF : 32'hFFFFFFFF;
        mask = mask << sh;
        ref_words[a[31:2]] = (w & ~mask) | ((d << sh) & mask);
    endtask

    task automatic preload(input bit [31:0] a, input bit [31:0] d);
        ref_store(a, d, 3'd2);
        dev_write(a, d, 3'd2);
    endtask

    // Predict this cycle's grant, memory drive and next response from the current inputs.
    task automatic predict();
        bit if_wins, ls_wins, mis;
        int size;
        {e_if_g, e_ls_g, e_re, e_we, e_addr, e_wd, e_f3} = '0;
        {n_if_v, n_if_e, n_if_d, n_ls_v, n_ls_e, n_ls_d} = '0;
        if_wins = 0; ls_wins = 0;
        if (!rst) begin
            if (if_req_i && ls_req_i) if_wins = (denied == LIMIT);
            else                      if_wins = if_req_i;
            ls_wins = ls_req_i && !if_wins;
        end
        if (if_wins) begin
            e_if_g = 1;
            mis = (if_addr_i % 4) != 0;
            n_if_v = 1; n_if_e = mis;
            if (!mis) begin
                e_re = 1; e_addr = if_addr_i; e_f3 = 3'd2;
                n_if_d = ref_load(if_addr_i, 3'd2);
            end
        end
        if (ls_wins) begin
            e_ls_g = 1;
            size = 1 << ls_funct3_i[1:0];
            mis = (ls_addr_i % size) != 0;
            n_ls_v = 1; n_ls_e = mis;
            if (!mis) begin
                e_addr = ls_addr_i; e_f3 = ls_funct3_i;
                if (ls_we_i) begin
                    e_we = 1; e_wd = ls_wdata_i;
                end else begin
                    e_re = 1; n_ls_d = ref_load(ls_addr_i, ls_funct3_i);
                end
            end
        end
        if (if_req_i && !if_wins) new_denied = (denied + 1 > LIMIT) ? LIMIT : denied + 1;
        else                      new_denied = 0;
    endtask

    task automatic commit();
        if (rst) begin
            denied = 0;
            {p_if_v, p_if_e, p_if_d, p_ls_v, p_ls_e, p_ls_d} = '0;
        end else begin
            denied = new_denied;
            {p_if_v, p_if_e, p_if_d} = {n_if_v, n_if_e, n_if_d};
            {p_ls_v, p_ls_e, p_ls_d} = {n_ls_v, n_ls_e, n_ls_d};
            if (e_we) ref_store(e_addr, e_wd, e_f3);
        end
    endtask

    // One clock: called and returns at a negedge, inputs already applied by the caller.
    task automatic cycle();
        predict();
        #1;
        mem_data_i = mem_read_en_o ? dev_read(mem_addr_o, mem_funct3_o) : 32'h0;
        #1;
        {s_if_g, s_ls_g, s_re, s_we} = {if_gnt_o, ls_gnt_o, mem_read_en_o, mem_write_en_o};
        {s_addr, s_wd, s_f3} = {mem_addr_o, mem_data_o, mem_funct3_o};
        @(posedge clk);
        if (s_we) dev_write(s_addr, s_wd, s_f3);
        commit();
        @(negedge clk);
    endtask

    task automatic set_ls(input bit req, input bit we, input bit [31:0] a, input bit [31:0] d,
                          input bit [2:0] f3);
        ls_req_i = req; ls_we_i = we; ls_addr_i = a; ls_wdata_i = d; ls_funct3_i = f3;
    endtask

    task automatic idle();
        rst = 0; if_req_i = 0; set_ls(0, 0, 0, 0, 0);
        cycle();
    endtask

    task automatic test_reset();
        rst = 1; if_req_i = 0; if_addr_i = 0; set_ls(0, 0, 0, 0, 0);
        cycle();
        total++;
        if ({if_rvalid_o, ls_rvalid_o, if_rdata_o, ls_rdata_o, if_err_o, ls_err_o} !== '0) begin
            bad++; $display("FAIL reset_outputs: got ifv=%b lsv=%b ifd=%h lsd=%h want all 0",
                            if_rvalid_o, ls_rvalid_o, if_rdata_o, ls_rdata_o);
        end
        // Load granted, then reset: the response must be discarded.
        rst = 0; set_ls(1, 0, 32'h01000000, 0, F3_LW);
        cycle();
        total++;
        if (s_ls_g !== 1'b1) begin bad++; $display("FAIL reset_pre_gnt: got %b want 1", s_ls_g); end
        rst = 1; if_req_i = 1; if_addr_i = 32'h01000000;
        cycle();
        total++;
        if ({s_if_g, s_ls_g, s_re, s_we} !== 4'b0) begin
            bad++; $display("FAIL reset_gnt_comb: got %b want 0000", {s_if_g, s_ls_g, s_re, s_we});
        end
        total++;
        if ({if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o, ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_err_o,
             mem_addr_o, mem_data_o, mem_read_en_o, mem_write_en_o, mem_funct3_o} !== '0) begin
            bad++; $display("FAIL reset_mid_traffic: ls_rvalid=%b mem_re=%b addr=%h want all 0",
                            ls_rvalid_o, mem_read_en_o, mem_addr_o);
        end
        idle();
    endtask

    task automatic test_if_fetch();
        preload(32'h01000000, 32'h00500093);
        if_req_i = 1; if_addr_i = 32'h01000000;
        cycle();
        total++;
        if ({s_if_g, s_re, s_addr, s_f3} !== {1'b1, 1'b1, 32'h01000000, 3'd2}) begin
            bad++; $display("FAIL if_grant: got g=%b re=%b a=%h f3=%0d want 1 1 01000000 2",
                            s_if_g, s_re, s_addr, s_f3);
        end
        if_req_i = 0;
        total++;
        if ({if_rvalid_o, if_err_o, if_rdata_o, ls_rvalid_o} !== {1'b1, 1'b0, 32'h00500093, 1'b0}) begin
            bad++; $display("FAIL if_response: got v=%b e=%b d=%h want 1 0 00500093", if_rvalid_o,
                            if_err_o, if_rdata_o);
        end
        cycle();
        total++;
        if (if_rvalid_o !== 1'b0) begin bad++; $display("FAIL if_rvalid_pulse: got %b want 0", if_rvalid_o); end
    endtask

    task automatic test_store_load();
        set_ls(1, 1, 32'h01000100, 32'hDEADBEEF, F3_SW);
        cycle();
        total++;
        if ({s_ls_g, s_we, s_re, s_wd} !== {1'b1, 1'b1, 1'b0, 32'hDEADBEEF}) begin
            bad++; $display("FAIL sw_drive: got g=%b we=%b re=%b d=%h want 1 1 0 deadbeef",
                            s_ls_g, s_we, s_re, s_wd);
        end
        set_ls(1, 0, 32'h01000103, 0, F3_LB);
        total++;
        if ({ls_rvalid_o, ls_err_o, ls_rdata_o} !== {1'b1, 1'b0, 32'h0}) begin
            bad++; $display("FAIL sw_response: got v=%b e=%b d=%h want 1 0 0", ls_rvalid_o, ls_err_o, ls_rdata_o);
        end
        cycle();
        set_ls(1, 0, 32'h01000103, 0, F3_LBU);
        total++;
        if ({ls_rvalid_o, ls_rdata_o} !== {1'b1, 32'hFFFFFFDE}) begin
            bad++; $display("FAIL lb_after_sw: got v=%b d=%h want 1 ffffffde", ls_rvalid_o, ls_rdata_o);
        end
        cycle();
        set_ls(0, 0, 0, 0, 0);
        total++;
        if ({ls_rvalid_o, ls_rdata_o} !== {1'b1, 32'h000000DE}) begin
            bad++; $display("FAIL lbu_after_sw: got v=%b d=%h want 1 000000de", ls_rvalid_o, ls_rdata_o);
        end
        cycle();
    endtask

    task automatic test_starvation();
        idle();
        if_req_i = 1; if_addr_i = 32'h01000000;
        set_ls(1, 0, 32'h01000100, 0, F3_LW);
        for (int i = 0; i < 15; i++) begin
            cycle();
            total++;
            if ({s_if_g, s_ls_g} !== {(i % 5) == 4, (i % 5) != 4}) begin
                bad++; $display("FAIL starve_pattern[%0d]: got if=%b ls=%b want if=%b", i, s_if_g, s_ls_g,
                                (i % 5) == 4);
            end
        end
        idle();
    endtask

    task automatic test_misaligned();
        set_ls(1, 0, 32'h01000102, 0, F3_LW);
        cycle();
        total++;
        if ({s_ls_g, s_re, s_we} !== 3'b100) begin
            bad++; $display("FAIL lw_mis_gnt: got g/re/we=%b want 100", {s_ls_g, s_re, s_we});
        end
        set_ls(1, 1, 32'h01000101, 32'h12345678, F3_SH);
        total++;
        if ({ls_rvalid_o, ls_err_o, ls_rdata_o} !== {2'b11, 32'h0}) begin
            bad++; $display("FAIL lw_mis_rsp: got v=%b e=%b d=%h want 1 1 0", ls_rvalid_o, ls_err_o, ls_rdata_o);
        end
        cycle();
        total++;
        if ({s_ls_g, s_re, s_we} !== 3'b100) begin
            bad++; $display("FAIL sh_mis_gnt: got g/re/we=%b want 100", {s_ls_g, s_re, s_we});
        end
        set_ls(0, 0, 0, 0, 0);
        if_req_i = 1; if_addr_i = 32'h01000002;
        total++;
        if ({ls_rvalid_o, ls_err_o, ls_rdata_o} !== {2'b11, 32'h0}) begin
            bad++; $display("FAIL sh_mis_rsp: got v=%b e=%b d=%h want 1 1 0", ls_rvalid_o, ls_err_o, ls_rdata_o);
        end
        cycle();
        if_req_i = 0;
        total++;
        if ({s_if_g, s_re, if_rvalid_o, if_err_o, if_rdata_o} !== {4'b1011, 32'h0}) begin
            bad++; $display("FAIL if_mis: got g=%b re=%b v=%b e=%b d=%h want 1 0 1 1 0", s_if_g, s_re,
                            if_rvalid_o, if_err_o, if_rdata_o);
        end
        idle();
    endtask

    task automatic test_if_drop();
        bit exp_if;
        idle();
        if_req_i = 1; if_addr_i = 32'h01000000;
        set_ls(1, 0, 32'h01000100, 0, F3_LW);
        for (int i = 0; i < 8; i++) begin
            if_req_i = (i != 2);
            cycle();
            // After the drop at step 2, IF waits 4 more losing cycles and wins at step 7.
            exp_if = (i == 7);
            total++;
            if ({s_if_g, s_ls_g} !== {exp_if, !exp_if}) begin
                bad++; $display("FAIL if_drop[%0d]: got if=%b ls=%b want if=%b", i, s_if_g, s_ls_g, exp_if);
            end
        end
        idle();
    endtask

    task automatic test_random();
        bit [2:0] ld_codes [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        for (int i = 0; i < 20; i++) preload(32'h01000100 + 4 * i, $urandom);
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            if (!(if_req_i && !s_if_g)) begin
                if_req_i = ($urandom_range(0, 2) != 0);
                if_addr_i = 32'h01000100 + 4 * $urandom_range(0, 7) + (($urandom_range(0, 9) == 0) ? 2 : 0);
            end
            if (!(ls_req_i && !s_ls_g)) begin
                ls_req_i = ($urandom_range(0, 3) != 0);
                ls_we_i = $urandom_range(0, 1);
                ls_addr_i = 32'h01000100 + $urandom_range(0, 31);
                ls_wdata_i = $urandom;
                ls_funct3_i = ls_we_i ? 3'($urandom_range(0, 2)) : ld_codes[$urandom_range(0, 4)];
            end
            total++;
            if ({if_rvalid_o, if_err_o, if_rdata_o, ls_rvalid_o, ls_err_o, ls_rdata_o} !==
                {p_if_v, p_if_e, p_if_d, p_ls_v, p_ls_e, p_ls_d}) begin
                bad++; $display("FAIL rand_rsp[%0d]: got if=%b/%b/%h ls=%b/%b/%h want if=%b/%b/%h ls=%b/%b/%h",
                                i, if_rvalid_o, if_err_o, if_rdata_o, ls_rvalid_o, ls_err_o, ls_rdata_o,
                                p_if_v, p_if_e, p_if_d, p_ls_v, p_ls_e, p_ls_d);
            end
            cycle();
            total++;
            if ({s_if_g, s_ls_g, s_re, s_we} !== {e_if_g, e_ls_g, e_re, e_we} ||
                ((s_re || s_we) && ({s_addr, s_f3, s_wd} !== {e_addr, e_f3, e_wd}))) begin
                bad++; $display("FAIL rand_gnt[%0d]: got g=%b%b re/we=%b%b a=%h f3=%0d d=%h want g=%b%b re/we=%b%b a=%h f3=%0d d=%h",
                                i, s_if_g, s_ls_g, s_re, s_we, s_addr, s_f3, s_wd,
                                e_if_g, e_ls_g, e_re, e_we, e_addr, e_f3, e_wd);
            end
        end
    endtask

    initial begin
        rst = 1; if_req_i = 0; if_addr_i = 0; mem_data_i = 0;
        set_ls(0, 0, 0, 0, 0);
        @(negedge clk);
        test_reset();
        test_if_fetch();
        test_store_load();
        test_starvation();
        test_misaligned();
        test_if_drop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
